// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
// Wishbone-programmable colour sequencer. A 4-entry colour table is stepped through
// with a linear per-channel fade toward each entry, a hold of a programmable number
// of prescaled ticks, then an advance to the next entry. Three 8-bit duty values
// drive the RGB PWM mixer; irq is a level raised when a sequence finishes.
module rgb_fade_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  duty_r,
    output logic [7:0]  duty_g,
    output logic [7:0]  duty_b,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_FADE, S_HOLD} state_t;

    localparam logic [7:0] OFF_CTRL  = 8'h00;
    localparam logic [7:0] OFF_STAT  = 8'h04;
    localparam logic [7:0] OFF_PRESC = 8'h08;

    // Bus-side registers: request is latched so the write lands on the ack cycle
    logic        ack_q;
    logic        we_q;
    logic [7:0]  off_q;
    logic [31:0] wdat_q;
    logic [31:0] rdat_q;

    // Configuration / status registers
    logic [2:0]        ctrl_q,  ctrl_d;   // [0]run [1]loop [2]irq_en
    logic              done_q,  done_d;
    logic [15:0]       presc_q, presc_d;
    logic [3:0][31:0]  entry_q, entry_d;  // [31:24]hold [23:16]R [15:8]G [7:0]B

    // Sequencer state
    state_t      state_q, state_d;
    logic [1:0]  index_q, index_d;
    logic [15:0] pcnt_q,  pcnt_d;
    logic [7:0]  hold_q,  hold_d;
    logic [7:0]  duty_r_q, duty_r_d;
    logic [7:0]  duty_g_q, duty_g_d;
    logic [7:0]  duty_b_q, duty_b_d;

    logic        req;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        wr_presc;
    logic        wr_entry;
    logic        tick;
    logic        at_target;
    logic [31:0] tgt;
    logic [31:0] rdata;
    logic        unused_sel;

    // Byte selects carry no meaning here: every write is a full word
    assign unused_sel = &{1'b0, wbs_sel_i};

    // One step of a duty value toward its target, clamped so it never wraps
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal);
        if (cur < goal) begin
            return cur + 8'd1;
        end else if (cur > goal) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

    // A new request is only accepted while ack is low, giving at most one ack every other cycle
    assign req = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]) && !ack_q;

    assign wr       = ack_q && we_q;
    assign wr_ctrl  = wr && (off_q == OFF_CTRL);
    assign wr_stat  = wr && (off_q == OFF_STAT);
    assign wr_presc = wr && (off_q == OFF_PRESC);
    assign wr_entry = wr && (off_q[7:4] == 4'h1) && (off_q[1:0] == 2'b00);

    assign tgt       = entry_q[index_q];
    assign at_target = (duty_r_q == tgt[23:16]) && (duty_g_q == tgt[15:8]) && (duty_b_q == tgt[7:0]);
    assign tick      = (state_q != S_IDLE) && (pcnt_q == presc_q);

    assign busy      = (state_q != S_IDLE);
    assign irq       = done_q && ctrl_q[2];
    assign duty_r    = duty_r_q;
    assign duty_g    = duty_g_q;
    assign duty_b    = duty_b_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;

    // Register read mux, decoded from the live address at request time
    always_comb begin
        rdata = 32'h0;
        case (wbs_adr_i[7:0])
            OFF_CTRL:  rdata = {29'h0, ctrl_q};
            OFF_STAT:  rdata = {28'h0, done_q, index_q, busy};
            OFF_PRESC: rdata = {16'h0, presc_q};
            8'h10, 8'h14, 8'h18, 8'h1C: rdata = entry_q[wbs_adr_i[3:2]];
            default:   rdata = 32'h0;
        endcase
    end

    // Wishbone handshake: ack and read data one cycle after an accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q  <= 1'b0;
            we_q   <= 1'b0;
            off_q  <= 8'h0;
            wdat_q <= 32'h0;
            rdat_q <= 32'h0;
        end else begin
            ack_q  <= req;
            rdat_q <= (req && !wbs_we_i) ? rdata : 32'h0;
            if (req) begin
                we_q   <= wbs_we_i;
                off_q  <= wbs_adr_i[7:0];
                wdat_q <= wbs_dat_i;
            end
        end
    end

    // Next-state: register writes, prescaler, IDLE/FADE/HOLD sequencing, CTRL overrides
    always_comb begin
        ctrl_d   = ctrl_q;
        done_d   = done_q;
        presc_d  = presc_q;
        entry_d  = entry_q;
        state_d  = state_q;
        index_d  = index_q;
        pcnt_d   = pcnt_q;
        hold_d   = hold_q;
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;

        if (wr_entry) begin
            entry_d[off_q[3:2]] = wdat_q;
        end
        if (wr_presc) begin
            presc_d = wdat_q[15:0];
        end
        if (wr_stat && wdat_q[3]) begin
            done_d = 1'b0;
        end

        if (state_q == S_IDLE) begin
            pcnt_d = 16'h0;
        end else if (tick) begin
            pcnt_d = 16'h0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        case (state_q)
            S_FADE: begin
                if (at_target) begin
                    state_d = S_HOLD;
                    hold_d  = tgt[31:24];
                end else if (tick) begin
                    duty_r_d = step_toward(duty_r_q, tgt[23:16]);
                    duty_g_d = step_toward(duty_g_q, tgt[15:8]);
                    duty_b_d = step_toward(duty_b_q, tgt[7:0]);
                end
            end
            S_HOLD: begin
                if (hold_q == 8'h0) begin
                    if (index_q != 2'd3) begin
                        index_d = index_q + 2'd1;
                        state_d = S_FADE;
                    end else if (ctrl_q[1]) begin
                        index_d = 2'd0;
                        state_d = S_FADE;
                    end else begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        ctrl_d[0] = 1'b0;
                    end
                end else if (tick) begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
            end
        endcase

        // A CTRL write takes priority over the sequencer's own progress this cycle
        if (wr_ctrl) begin
            ctrl_d[2:1] = wdat_q[2:1];
            if (!wdat_q[0]) begin
                ctrl_d[0] = 1'b0;
                state_d   = S_IDLE;
                index_d   = index_q;
                duty_r_d  = duty_r_q;
                duty_g_d  = duty_g_q;
                duty_b_d  = duty_b_q;
            end else if (state_q == S_IDLE) begin
                ctrl_d[0] = 1'b1;
                state_d   = S_FADE;
                index_d   = 2'd0;
                done_d    = 1'b0;
                pcnt_d    = 16'h0;
            end
        end
    end

    // State register for configuration and sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= 3'h0;
            done_q   <= 1'b0;
            presc_q  <= 16'h0;
            entry_q  <= '0;
            state_q  <= S_IDLE;
            index_q  <= 2'd0;
            pcnt_q   <= 16'h0;
            hold_q   <= 8'h0;
            duty_r_q <= 8'h0;
            duty_g_q <= 8'h0;
            duty_b_q <= 8'h0;
        end else begin
            ctrl_q   <= ctrl_d;
            done_q   <= done_d;
            presc_q  <= presc_d;
            entry_q  <= entry_d;
            state_q  <= state_d;
            index_q  <= index_d;
            pcnt_q   <= pcnt_d;
            hold_q   <= hold_d;
            duty_r_q <= duty_r_d;
            duty_g_q <= duty_g_d;
            duty_b_q <= duty_b_d;
        end
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: register reset values, fade/hold timing,
// prescaled ticks, looping and stop, done/irq handling and Wishbone handshake.
module tb_rgb_fade_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        reset;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  duty_r;
    logic [7:0]  duty_g;
    logic [7:0]  duty_b;
    logic        busy;
    logic        irq;

    int checks = 0;
    int errors = 0;

    rgb_fade_sequencer #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .duty_r    (duty_r),
        .duty_g    (duty_g),
        .duty_b    (duty_b),
        .busy      (busy),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single access; returns at the negedge where ack was seen (or after 4 cycles without ack)
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             output logic [31:0] rd, output logic acked);
        @(negedge clk);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        acked = 1'b0;
        rd    = 32'h0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                acked = 1'b1;
                rd    = wbs_dat_o;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        logic        ak;
        wb_access(1'b1, adr, dat, rd, ak);
        chk({tag, "_ack"}, {31'h0, ak}, 32'h1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ak;
        wb_access(1'b0, adr, 32'h0, rd, ak);
        chk({tag, "_ack"}, {31'h0, ak}, 32'h1);
        chk(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ak;
        int          n;
        int          acks;

        reset     = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_dat_i = 32'h0;
        wbs_adr_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        chk("rst_ack",  {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_duty", {8'h0, duty_r, duty_g, duty_b}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_irq",  {31'h0, irq}, 32'h0);
        rd_chk("rst_ctrl",  BASE + 32'h00, 32'h0);
        rd_chk("rst_stat",  BASE + 32'h04, 32'h0);
        rd_chk("rst_presc", BASE + 32'h08, 32'h0);
        rd_chk("rst_e0",    BASE + 32'h10, 32'h0);
        rd_chk("rst_e1",    BASE + 32'h14, 32'h0);
        rd_chk("rst_e2",    BASE + 32'h18, 32'h0);
        rd_chk("rst_e3",    BASE + 32'h1C, 32'h0);

        // 2: PRESC=0 fade of red to 10, hold 2, back to 0, done + irq
        wr("t2_presc", BASE + 32'h08, 32'h0);
        wr("t2_e0",    BASE + 32'h10, 32'h020A_0000);
        wr("t2_e1",    BASE + 32'h14, 32'h0);
        wr("t2_e2",    BASE + 32'h18, 32'h0);
        wr("t2_e3",    BASE + 32'h1C, 32'h0);
        rd_chk("t2_e0_rb", BASE + 32'h10, 32'h020A_0000);
        wr("t2_ctrl",  BASE + 32'h00, 32'h5);
        @(negedge clk);
        chk("t2_busy_lat", {31'h0, busy}, 32'h1);
        chk("t2_r0",  {24'h0, duty_r}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t2_r5",  {24'h0, duty_r}, 32'd5);
        repeat (5) @(negedge clk);
        chk("t2_r10", {24'h0, duty_r}, 32'd10);
        @(negedge clk);
        chk("t2_r10_hold", {24'h0, duty_r}, 32'd10);
        chk("t2_gb", {16'h0, duty_g, duty_b}, 32'h0);
        n = 11;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t2_run_cycles", n, 32'd30);
        chk("t2_irq",  {31'h0, irq}, 32'h1);
        chk("t2_duty_end", {8'h0, duty_r, duty_g, duty_b}, 32'h0);
        rd_chk("t2_stat", BASE + 32'h04, 32'hE);
        rd_chk("t2_ctrl_rb", BASE + 32'h00, 32'h4);
        wr("t2_stat_w0", BASE + 32'h04, 32'h0);
        @(negedge clk);
        chk("t2_irq_keep", {31'h0, irq}, 32'h1);
        wr("t2_stat_clr", BASE + 32'h04, 32'h8);
        @(negedge clk);
        chk("t2_irq_clr", {31'h0, irq}, 32'h0);
        rd_chk("t2_stat_clr_rb", BASE + 32'h04, 32'h6);

        // 3: PRESC=3, blue steps every 4th cycle
        wr("t3_presc", BASE + 32'h08, 32'h3);
        wr("t3_e0",    BASE + 32'h10, 32'h0000_0004);
        wr("t3_ctrl",  BASE + 32'h00, 32'h1);
        repeat (4) @(negedge clk);
        chk("t3_b_c4",  {24'h0, duty_b}, 32'd0);
        @(negedge clk);
        chk("t3_b_c5",  {24'h0, duty_b}, 32'd1);
        repeat (11) @(negedge clk);
        chk("t3_b_c16", {24'h0, duty_b}, 32'd3);
        @(negedge clk);
        chk("t3_b_c17", {24'h0, duty_b}, 32'd4);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t3_end_busy", {31'h0, busy}, 32'h0);
        chk("t3_irq_off",  {31'h0, irq}, 32'h0);
        chk("t3_b_end",    {24'h0, duty_b}, 32'd0);
        rd_chk("t3_stat",  BASE + 32'h04, 32'hE);

        // 4: looping run, stop mid-fade, duties freeze
        wr("t4_presc", BASE + 32'h08, 32'h0);
        wr("t4_e0",    BASE + 32'h10, 32'h0000_0008);
        wr("t4_ctrl",  BASE + 32'h00, 32'h3);
        repeat (26) @(negedge clk);
        chk("t4_wrap_busy", {31'h0, busy}, 32'h1);
        chk("t4_wrap_b",    {24'h0, duty_b}, 32'd1);
        wr("t4_stop", BASE + 32'h00, 32'h0);
        @(negedge clk);
        chk("t4_stop_busy", {31'h0, busy}, 32'h0);
        chk("t4_frozen",    {24'h0, duty_b}, 32'd3);
        repeat (5) @(negedge clk);
        chk("t4_frozen_5",  {24'h0, duty_b}, 32'd3);
        chk("t4_irq",       {31'h0, irq}, 32'h0);
        rd_chk("t4_stat",   BASE + 32'h04, 32'h0);

        // 5: back-to-back strobe, unmapped offset, foreign address
        wr("t5_presc", BASE + 32'h08, 32'h1234);
        @(negedge clk);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BASE + 32'h08;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                acks++;
                chk("t5_b2b_dat", wbs_dat_o, 32'h1234);
            end else begin
                chk("t5_idle_dat", wbs_dat_o, 32'h0);
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        chk("t5_ack_count", acks, 32'd3);
        wr("t5_unmapped_w", BASE + 32'h0C, 32'hFFFF_FFFF);
        rd_chk("t5_unmapped_r", BASE + 32'h0C, 32'h0);
        wb_access(1'b0, BASE + 32'h100, 32'h0, rd, ak);
        chk("t5_foreign_noack", {31'h0, ak}, 32'h0);
        wb_access(1'b1, 32'h4000_0008, 32'h55, rd, ak);
        chk("t5_foreign_w_noack", {31'h0, ak}, 32'h0);
        rd_chk("t5_presc_kept", BASE + 32'h08, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
